// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush/stall priority and 1-entry hold buffer
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            stall,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_instr,
   input  logic [XLEN-1:0] resp_pc,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            valid,
   output logic            hold_valid
);

   logic [XLEN-1:0] hold_instr;
   logic [XLEN-1:0] hold_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         instr      <= XLEN'(NOP_INSTR);
         pc         <= '0;
         pc_plus4   <= '0;
         valid      <= 1'b0;
         hold_valid <= 1'b0;
         hold_instr <= '0;
         hold_pc    <= '0;
      end else if (flush) begin
         instr      <= XLEN'(NOP_INSTR);
         valid      <= 1'b0;
         hold_valid <= 1'b0;
      end else if (stall) begin
         // Decode is frozen: park a response that lands now so it is not lost
         if (resp_valid) begin
            hold_valid <= 1'b1;
            hold_instr <= resp_instr;
            hold_pc    <= resp_pc;
         end
      end else if (hold_valid) begin
         instr      <= hold_instr;
         pc         <= hold_pc;
         pc_plus4   <= hold_pc + XLEN'(4);
         valid      <= 1'b1;
         hold_valid <= 1'b0;
      end else if (resp_valid) begin
         instr    <= resp_instr;
         pc       <= resp_pc;
         pc_plus4 <= resp_pc + XLEN'(4);
         valid    <= 1'b1;
      end else begin
         instr <= XLEN'(NOP_INSTR);
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage: PCF, req/gnt/rvalid FSM, IF/ID; FETCH_PERF_CNT_EN adds FetchCnt/DropCnt
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     FetchCnt,
   output logic [31:0]     DropCnt
`endif
);

   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pcf, pcf_n;
   logic            accept;
   logic            hold_valid;

   assign imem_addr = pcf;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= REQ;
         pcf   <= RESET_PC;
      end else begin
         state <= state_n;
         pcf   <= pcf_n;
      end
   end

   always_comb begin
      state_n  = state;
      pcf_n    = pcf;
      imem_req = 1'b0;
      accept   = 1'b0;
      case (state)
         REQ: begin
            // Gating on hold_valid keeps the hold buffer free for any outstanding response
            imem_req = !StallF && !hold_valid;
            if (imem_req && imem_gnt)
               state_n = PCSrcE ? DISCARD : WAIT;
            if (PCSrcE)
               pcf_n = PCTargetE;
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_n = REQ;
               if (PCSrcE) begin
                  pcf_n = PCTargetE;
               end else begin
                  accept = 1'b1;
                  pcf_n  = pcf + XLEN'(4);
               end
            end else if (PCSrcE) begin
               state_n = DISCARD;
               pcf_n   = PCTargetE;
            end
         end
         DISCARD: begin
            if (PCSrcE)
               pcf_n = PCTargetE;
            if (imem_rvalid)
               state_n = REQ;
         end
         default: state_n = REQ;
      endcase
   end

   if_id_reg #(.XLEN(XLEN)) u_if_id (
      .clk        (clk),
      .reset      (reset),
      .flush      (FlushD),
      .stall      (StallD),
      .resp_valid (accept),
      .resp_instr (imem_rdata),
      .resp_pc    (pcf),
      .instr      (InstrD),
      .pc         (PCD),
      .pc_plus4   (PCPlus4D),
      .valid      (ValidD),
      .hold_valid (hold_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic drop;
   assign drop = imem_rvalid && ((state == WAIT && PCSrcE) || state == DISCARD);

   always_ff @(posedge clk) begin
      if (reset) begin
         FetchCnt <= '0;
         DropCnt  <= '0;
      end else begin
         if (accept) FetchCnt <= FetchCnt + 32'd1;
         if (drop)   DropCnt  <= DropCnt + 32'd1;
      end
   end
`endif

endmodule
